pc_sequencer: RTL and testbench

Fetch/execute control sequencer for the picoRISC core. It sits directly upstream of the program counter. It latches the instruction word read from program memory at `pc_out` and decodes it. It then drives the PC's `pc_inc` / `pc_absbranch` / `pc_relbranch` / `branchaddr` inputs, plus ALU, register-write and I/O handshake controls. Every non-I/O instruction takes exactly two cycles (FETCH, EXEC).

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 56 +++++
 tb/tb_pc_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction, flag, I/O and PC/ALU control signals of the fetch/execute sequencer.
interface pc_sequencer_if #(
  parameter int p = 6,
  parameter int I = 16
);
  logic [I-1:0] instr;
  logic         z_flag;
  logic         c_flag;
  logic         io_ack;
  logic         pc_inc;
  logic         pc_absbranch;
  logic         pc_relbranch;
  logic [p-1:0] branchaddr;
  logic [2:0]   alu_op;
  logic         reg_we;
  logic         imm_sel;
  logic         io_req;
  logic         io_we;
  logic         illegal;
  logic         halted;
  modport master (
    input  instr, z_flag, c_flag, io_ack,
    output pc_inc, pc_absbranch, pc_relbranch, branchaddr, alu_op,
           reg_we, imm_sel, io_req, io_we, illegal, halted
  );
  modport slave (
    output instr, z_flag, c_flag, io_ack,
    input  pc_inc, pc_absbranch, pc_relbranch, branchaddr, alu_op,
           reg_we, imm_sel, io_req, io_we, illegal, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: two-cycle fetch/execute control sequencer with I/O handshake stall and HALT.
module pc_sequencer #(
  parameter int p = 6,
  parameter int I = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  pc_sequencer_if.master bus
);
  typedef enum logic [1:0] {FETCH, EXEC, IOWAIT, HALT} state_e;
  state_e       state_q, state_d;
  logic [3:0]   op_q;
  logic [2:0]   alu_q;
  logic [p-1:0] ba_q;
  logic         exec, io_cyc, done, cond, ill;
  // Only the opcode, ALU field and address field of IR are ever decoded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      op_q    <= '0;
      alu_q   <= '0;
      ba_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) begin
        op_q  <= bus.instr[I-1:I-4];
        alu_q <= bus.instr[10:8];
        ba_q  <= bus.instr[p-1:0];
      end
    end
  end
  always_comb begin
    exec   = state_q == EXEC;
    io_cyc = (exec && (op_q == 4'h8 || op_q == 4'h9)) || state_q == IOWAIT;
    done   = io_cyc && bus.io_ack;
    cond   = op_q == 4'h5 ? bus.z_flag : op_q == 4'h6 ? !bus.z_flag :
             op_q == 4'h7 ? bus.c_flag : op_q == 4'h4;
    ill    = exec && op_q >= 4'hA && op_q <= 4'hE;
    state_d = state_q == FETCH ? EXEC :
              state_q == HALT ? HALT :
              exec && op_q == 4'hF ? HALT :
              io_cyc && !bus.io_ack ? IOWAIT : FETCH;
  end
  assign bus.pc_relbranch = exec && cond;
  assign bus.pc_absbranch = exec && op_q == 4'h3;
  assign bus.pc_inc       = done || ill ||
                            (exec && (op_q <= 4'h2 || (op_q >= 4'h5 && op_q <= 4'h7 && !cond)));
  assign bus.branchaddr   = ba_q;
  assign bus.alu_op       = exec && op_q == 4'h1 ? alu_q : 3'd0;
  assign bus.reg_we       = (exec && (op_q == 4'h1 || op_q == 4'h2)) || (done && op_q == 4'h8);
  assign bus.imm_sel      = exec && op_q == 4'h2;
  assign bus.io_req       = io_cyc;
  assign bus.io_we        = io_cyc && op_q == 4'h9;
  assign bus.illegal      = ill;
  assign bus.halted       = state_q == HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus randomized run against an instruction-level model.
module tb_pc_sequencer;
  localparam logic [17:0] INC = 18'h20000, ABS = 18'h10000, REL = 18'h08000;
  localparam logic [17:0] WE = 18'h20, IMM = 18'h10, REQ = 18'h8, IOWE = 18'h4, ILL = 18'h2, HLT = 18'h1;
  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        z, c, ack;
    logic [17:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0, cyc = 0;
  int mph = 0;
  logic [15:0] mir = '0;
  vec_t tbl[$];
  pc_sequencer_if #(.p(6), .I(16)) ifc ();
  pc_sequencer #(.p(6), .I(16)) dut (.clk_i(clk), .rst_i(rst), .bus(ifc));
  always #5 clk = ~clk;
  function automatic logic [17:0] ba(input logic [5:0] a);
    return {3'b0, a, 9'b0};
  endfunction
  function automatic logic [17:0] alu(input logic [2:0] a);
    return {9'b0, a, 6'b0};
  endfunction
  // Phases: 0 fetch, 1 first execute cycle, 2 waiting for I/O ack, 3 halted.
  function automatic logic [17:0] model_out(input logic z, c, a);
    logic [3:0] op = mir[15:12];
    logic [17:0] r = ba(mir[5:0]);
    if (mph == 1) begin
      case (op)
        4'h0: r |= INC;
        4'h1: r |= INC | WE | alu(mir[10:8]);
        4'h2: r |= INC | WE | IMM;
        4'h3: r |= ABS;
        4'h4: r |= REL;
        4'h5: r |= z ? REL : INC;
        4'h6: r |= z ? INC : REL;
        4'h7: r |= c ? REL : INC;
        4'h8: r |= REQ | (a ? INC | WE : 18'h0);
        4'h9: r |= REQ | IOWE | (a ? INC : 18'h0);
        4'hF: r |= 18'h0;
        default: r |= INC | ILL;
      endcase
    end else if (mph == 2) begin
      r |= REQ | (op == 4'h9 ? IOWE : 18'h0);
      if (a) r |= INC | (op == 4'h8 ? WE : 18'h0);
    end else if (mph == 3) r |= HLT;
    return r;
  endfunction
  task automatic model_next(input logic r, input logic [15:0] in, input logic a);
    if (r) begin
      mph = 0;
      mir = '0;
    end else if (mph == 0) begin
      mph = 1;
      mir = in;
    end else if (mph == 1) begin
      if (mir[15:12] == 4'hF) mph = 3;
      else if ((mir[15:12] == 4'h8 || mir[15:12] == 4'h9) && !a) mph = 2;
      else mph = 0;
    end else if (mph == 2 && a) mph = 0;
  endtask
  task automatic step(input logic r, input logic [15:0] in, input logic z, c, a,
                      input logic use_tbl, input logic [17:0] texp, input string nm);
    logic [17:0] got, exp;
    rst = r;
    ifc.instr = in;
    ifc.z_flag = z;
    ifc.c_flag = c;
    ifc.io_ack = a;
    #4;
    got = {ifc.pc_inc, ifc.pc_absbranch, ifc.pc_relbranch, ifc.branchaddr, ifc.alu_op,
           ifc.reg_we, ifc.imm_sel, ifc.io_req, ifc.io_we, ifc.illegal, ifc.halted};
    exp = use_tbl ? texp : model_out(z, c, a);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h exp %h", nm, cyc, got, exp);
    end
    model_next(r, in, a);
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic r, input logic [15:0] in, input logic z, c, a, input logic [17:0] e);
    tbl.push_back('{rst: r, instr: in, z: z, c: c, ack: a, exp: e});
  endtask
  initial begin
    ifc.instr = 16'h3025;
    ifc.z_flag = 0;
    ifc.c_flag = 0;
    ifc.io_ack = 0;
    @(posedge clk);
    model_next(1'b1, 16'h3025, 1'b0);
    #1;
    add(1, 16'h3025, 0, 0, 0, 18'h0);
    add(0, 16'h3025, 0, 0, 0, 18'h0);
    add(0, 16'h3025, 0, 0, 0, ABS | ba(6'h25));
    add(0, 16'h0000, 0, 0, 0, ba(6'h25));
    for (int i = 0; i < 7; i++) add(0, 16'h0000, 0, 0, 0, i % 2 == 0 ? INC : 18'h0);
    add(0, 16'h503D, 1, 0, 0, 18'h0);
    add(0, 16'h503D, 0, 0, 0, INC | ba(6'h3D));
    add(0, 16'h503D, 1, 0, 0, ba(6'h3D));
    add(0, 16'h503D, 1, 0, 0, REL | ba(6'h3D));
    add(0, 16'h8000, 0, 0, 1, ba(6'h3D));
    add(0, 16'h8000, 0, 0, 0, REQ);
    add(0, 16'h8000, 1, 1, 0, REQ);
    add(0, 16'h8000, 0, 1, 0, REQ);
    add(0, 16'h8000, 0, 0, 1, REQ | INC | WE);
    add(0, 16'h9000, 0, 0, 1, 18'h0);
    add(0, 16'h9000, 0, 0, 1, REQ | IOWE | INC);
    add(0, 16'h8000, 0, 0, 0, 18'h0);
    add(0, 16'h8000, 0, 0, 0, REQ);
    add(0, 16'h8000, 0, 0, 0, REQ);
    add(1, 16'h8000, 0, 0, 0, REQ);
    add(0, 16'hF000, 0, 0, 1, 18'h0);
    add(0, 16'hF000, 1, 1, 1, 18'h0);
    for (int i = 0; i < 10; i++) add(0, i % 2 ? 16'h3FFF : 16'h0000, i[0], i[1], 1, HLT);
    add(1, 16'hA000, 0, 0, 0, HLT);
    add(0, 16'hA000, 0, 0, 0, 18'h0);
    add(0, 16'hA000, 0, 0, 0, INC | ILL);
    add(0, 16'h1234, 0, 0, 0, 18'h0);
    add(0, 16'h1234, 0, 0, 0, INC | WE | alu(3'd2) | ba(6'h34));
    add(0, 16'h21FF, 0, 0, 0, ba(6'h34));
    add(0, 16'h21FF, 0, 0, 0, INC | WE | IMM | ba(6'h3F));
    add(0, 16'h6005, 1, 0, 0, ba(6'h3F));
    add(0, 16'h6005, 1, 0, 0, INC | ba(6'h05));
    add(0, 16'h7001, 0, 1, 0, ba(6'h05));
    add(0, 16'h7001, 0, 1, 0, REL | ba(6'h01));
    add(0, 16'h4010, 0, 0, 0, ba(6'h01));
    add(0, 16'h4010, 0, 0, 0, REL | ba(6'h10));
    foreach (tbl[k]) step(tbl[k].rst, tbl[k].instr, tbl[k].z, tbl[k].c, tbl[k].ack, 1'b1, tbl[k].exp, "vector");
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 39) == 0, 16'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 2) == 0, 1'b0, 18'h0, "random");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
